packed_index_alloc: RTL and testbench



---
 rtl/packed_index_alloc.sv | 55 +++++
 tb/tb_packed_index_alloc.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/packed_index_alloc.sv
// packed_index_alloc: lowest-free index allocator over a 2**IDX_W occupancy mask; PACKED_INDEX_ALLOC_CHECK_EN adds free consistency checking
module packed_index_alloc #(
  parameter int IDX_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  alloc_valid,
  input  logic                  alloc_ready,
  output logic [IDX_W-1:0]      alloc_idx,
  input  logic                  free_valid,
  input  logic [IDX_W-1:0]      free_idx,
  input  logic [2**IDX_W-1:0]   free_sel,
  output logic [IDX_W:0]        count,
  output logic                  full,
  output logic                  empty,
  output logic                  err
);
  localparam int N = 2**IDX_W;
  logic [N-1:0]   r_mask;
  logic [IDX_W:0] r_count;
  logic           w_alloc;
  logic           w_free;
  always_comb begin
    alloc_idx = '0;
    for (int i = N-1; i >= 0; i--) if (!r_mask[i]) alloc_idx = IDX_W'(i);
  end
  assign count       = r_count;
  assign full        = r_count == (IDX_W+1)'(N);
  assign empty       = r_count == '0;
  assign alloc_valid = !full && rst_n;
  assign w_alloc     = alloc_valid && alloc_ready;
  // a free only counts when the entry is really held, so count can never underflow
  assign w_free      = free_valid && r_mask[free_idx];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mask  <= '0;
      r_count <= '0;
    end else begin
      r_mask  <= (r_mask | ({N{w_alloc}} & (N'(1) << alloc_idx))) & ~({N{w_free}} & (N'(1) << free_idx));
      r_count <= r_count + (IDX_W+1)'(w_alloc) - (IDX_W+1)'(w_free);
    end
  end
`ifdef PACKED_INDEX_ALLOC_CHECK_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (!rst_n) r_err <= 1'b0;
    else if (free_valid && (free_sel != (N'(1) << free_idx) || !r_mask[free_idx])) r_err <= 1'b1;
  end
  assign err = r_err;
`else
  logic w_unused;
  assign w_unused = ^free_sel;
  assign err      = 1'b0;
`endif
endmodule

// File: tb/tb_packed_index_alloc.sv
// tb_packed_index_alloc: directed stimulus, per-cycle model comparison plus literal spot checks
module tb_packed_index_alloc;
`ifdef PACKED_INDEX_ALLOC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_valid, alloc_ready = 1'b0;
  logic [4:0]  alloc_idx;
  logic        free_valid = 1'b0;
  logic [4:0]  free_idx = '0;
  logic [31:0] free_sel = '0;
  logic [5:0]  count;
  logic        full, empty, err;
  int vectors = 0;
  int miscompares = 0;
  bit m_used [32];
  bit m_err = 1'b0;

  packed_index_alloc #(.IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_idx(alloc_idx), .free_valid(free_valid), .free_idx(free_idx), .free_sel(free_sel),
    .count(count), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int used_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_used[i]);
    return n;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < 32; i++) if (!m_used[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: a set of held entries; err latches on any bad free
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_used[i] <= 1'b0;
      m_err <= 1'b0;
    end else begin
      if (free_valid && m_used[free_idx]) m_used[free_idx] <= 1'b0;
      if (CHK && free_valid && (!m_used[free_idx] || free_sel != (32'd1 << free_idx))) m_err <= 1'b1;
      if (alloc_ready && used_cnt() < 32) m_used[lowest_free()] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("alloc_valid", 32'(alloc_valid), 32'(rst_n && used_cnt() < 32));
    if (alloc_valid) chk("alloc_idx", 32'(alloc_idx), 32'(lowest_free()));
    chk("count", 32'(count), 32'(used_cnt()));
    chk("full", 32'(full), 32'(used_cnt() == 32));
    chk("empty", 32'(empty), 32'(used_cnt() == 0));
    chk("err", 32'(err), 32'(m_err));
  end

  task automatic step(input bit ar, input bit fv, input int fi, input logic [31:0] fs, input bit rn);
    alloc_ready = ar;
    free_valid  = fv;
    free_idx    = 5'(fi);
    free_sel    = fs;
    rst_n       = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
  endtask

  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("lit_rst_valid", 32'(alloc_valid), 1);
    chk("lit_rst_idx", 32'(alloc_idx), 0);
    chk("lit_rst_empty", 32'(empty), 1);
    chk("lit_rst_full", 32'(full), 0);
    for (int i = 0; i < 32; i++) begin
      chk("lit_seq_idx", 32'(alloc_idx), 32'(i));
      step(1, 0, 0, 0, 1);
    end
    chk("lit_full_count", 32'(count), 32);
    chk("lit_full_flag", 32'(full), 1);
    chk("lit_full_valid", 32'(alloc_valid), 0);
    step(1, 0, 0, 0, 1);
    chk("lit_full_hold", 32'(count), 32);
    step(0, 1, 7, 32'h80, 1);
    chk("lit_free7_valid", 32'(alloc_valid), 1);
    chk("lit_free7_idx", 32'(alloc_idx), 7);
    chk("lit_free7_count", 32'(count), 31);
    chk("lit_free7_err", 32'(err), 0);
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);
    step(1, 1, 2, 32'h4, 1);
    chk("lit_both_count", 32'(count), 5);
    chk("lit_both_idx", 32'(alloc_idx), 2);
    step(0, 1, 9, 32'h200, 1);
    chk("lit_dbl_count", 32'(count), 5);
    chk("lit_dbl_err", 32'(err), 32'(CHK));
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);
    step(0, 1, 3, 32'h10, 1);
    chk("lit_sel_count", 32'(count), 4);
    chk("lit_sel_idx", 32'(alloc_idx), 3);
    chk("lit_sel_err", 32'(err), 32'(CHK));
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("lit_sel_sticky", 32'(err), 32'(CHK));
    step(1, 1, 3, 32'h8, 1);
    chk("lit_offered_free_count", 32'(count), 5);
    step(1, 1, 1, 32'h2, 0);
    chk("lit_rst_count", 32'(count), 0);
    chk("lit_rst_err", 32'(err), 0);
    chk("lit_rst_valid_low", 32'(alloc_valid), 0);
    step(0, 0, 0, 0, 1);
    chk("lit_rst2_idx", 32'(alloc_idx), 0);
    chk("lit_rst2_valid", 32'(alloc_valid), 1);
    for (int i = 0; i < 6; i++) step(1, (i % 2) == 1, i - 1, 32'd1 << (i - 1), 1);
    step(0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
